// File: rtl/post_normalizer.sv
// FP32 adder back end: normalizes the raw mantissa sum over several cycles,
// rounds to nearest-even and packs an IEEE-754 single, with valid/ready on both sides.
module post_normalizer #(
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign,
    input  logic [7:0]  exp,
    input  logic [27:0] mantis_sum,
    input  logic [2:0]  type_res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        flag_ovf,
    output logic        flag_unf,
    output logic        flag_inexact
);
    localparam int unsigned MW = 28;
    localparam int unsigned EW = 9;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t          state_q, state_d;
    logic            sign_q, sign_d;
    logic [EW-1:0]   exp_q, exp_d;
    logic [MW-1:0]   m_q, m_d;
    logic [2:0]      type_q, type_d;
    logic            in_ready_d, out_valid_d;
    logic [31:0]     result_d;
    logic            ovf_d, unf_d, inexact_d;

    logic [4:0]      lz, k;
    logic [EW-1:0]   exp_m1, exp_fin;
    logic            round_up, inexact;
    logic [24:0]     m_rnd;
    logic [22:0]     frac_fin;
    logic            hidden_fin;
    logic [7:0]      exp_field;

    // Leading zeros of the hidden+fraction+GRS field (bit 26 downward)
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            m_q          <= '0;
            type_q       <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            result       <= '0;
            flag_ovf     <= 1'b0;
            flag_unf     <= 1'b0;
            flag_inexact <= 1'b0;
        end else begin
            state_q      <= state_d;
            sign_q       <= sign_d;
            exp_q        <= exp_d;
            m_q          <= m_d;
            type_q       <= type_d;
            in_ready     <= in_ready_d;
            out_valid    <= out_valid_d;
            result       <= result_d;
            flag_ovf     <= ovf_d;
            flag_unf     <= unf_d;
            flag_inexact <= inexact_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        m_d       = m_q;
        type_d    = type_q;
        result_d  = result;
        ovf_d     = flag_ovf;
        unf_d     = flag_unf;
        inexact_d = flag_inexact;

        // Left-shift amount, clamped so the exponent never drops below 1
        lz     = lzc27(m_q[26:0]);
        exp_m1 = exp_q - 9'd1;
        k      = 5'(SHIFT_STEP);
        if (lz < k) k = lz;
        if (exp_m1 < {4'b0, k}) k = exp_m1[4:0];

        // Nearest-even rounding at bit 3; a carry into bit 27 renormalizes by one
        inexact    = |m_q[2:0];
        round_up   = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
        m_rnd      = m_q[27:3] + 25'(round_up);
        exp_fin    = m_rnd[24] ? exp_q + 9'd1 : exp_q;
        frac_fin   = m_rnd[24] ? m_rnd[23:1] : m_rnd[22:0];
        hidden_fin = m_rnd[24] | m_rnd[23];
        exp_field  = hidden_fin ? exp_fin[7:0] : 8'd0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = sign;
                    exp_d   = (exp == 8'd0) ? 9'd1 : {1'b0, exp};
                    m_d     = mantis_sum;
                    type_d  = type_res;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (type_q != 3'd0) begin
                    state_d = ROUND;
                end else if (m_q[27]) begin
                    m_d     = {1'b0, m_q[27:2], m_q[1] | m_q[0]};
                    exp_d   = exp_q + 9'd1;
                    state_d = ROUND;
                end else if (m_q[26] || (m_q == '0) || (exp_q == 9'd1)) begin
                    state_d = ROUND;
                end else begin
                    m_d   = m_q << k;
                    exp_d = exp_q - {4'b0, k};
                end
            end
            ROUND: begin
                ovf_d     = 1'b0;
                unf_d     = 1'b0;
                inexact_d = 1'b0;
                unique case (type_q)
                    3'd0: begin
                        if (m_q == '0) begin
                            result_d = 32'h0000_0000;
                        end else if (exp_fin >= 9'd255) begin
                            result_d  = {sign_q, 8'hFF, 23'd0};
                            ovf_d     = 1'b1;
                            inexact_d = 1'b1;
                        end else begin
                            result_d  = {sign_q, exp_field, frac_fin};
                            inexact_d = inexact;
                            unf_d     = (exp_field == 8'd0) & inexact;
                        end
                    end
                    3'd1:    result_d = {sign_q, 31'd0};
                    3'd2:    result_d = {sign_q, 8'hFF, 23'd0};
                    default: result_d = 32'h7FC0_0000;
                endcase
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end
endmodule

// File: tb/tb_post_normalizer.sv
// Directed table-driven bench for post_normalizer (SHIFT_STEP=1), plus
// backpressure and mid-operation reset sequences.
module tb_post_normalizer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mantis_sum;
    logic [2:0]  type_res;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_ovf;
    logic        flag_unf;
    logic        flag_inexact;

    int n_cmp  = 0;
    int n_fail = 0;

    post_normalizer #(.SHIFT_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign(sign), .exp(exp), .mantis_sum(mantis_sum), .type_res(type_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_ovf(flag_ovf), .flag_unf(flag_unf),
        .flag_inexact(flag_inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [7:0]  e;
        logic [27:0] m;
        logic [2:0]  t;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drive one op, wait for out_valid, check latency/result/flags, optionally stall, then handshake
    task automatic run_op(input vec_t v, input string name, input int hold);
        int cyc;
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({name, ".in_ready"}, 32'(in_ready), 32'd1);
        sign = v.sgn; exp = v.e; mantis_sum = v.m; type_res = v.t; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, ".latency"}, 32'(cyc), 32'(v.lat));
        check({name, ".result"}, result, v.res);
        check({name, ".flags"}, {29'd0, flag_ovf, flag_unf, flag_inexact},
              {29'd0, v.ovf, v.unf, v.inx});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, ".hold_result"}, result, v.res);
            check({name, ".hold_valid_ready"}, {30'd0, out_valid, in_ready}, 32'b10);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, ".after_hs"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        //         sgn  exp     m              t     result          ovf  unf  inx  lat
        vecs[0]  = '{0, 8'd127, 28'h8000000, 3'd0, 32'h40000000, 0, 0, 0, 2};
        vecs[1]  = '{0, 8'd127, 28'h2000000, 3'd0, 32'h3F000000, 0, 0, 0, 3};
        vecs[2]  = '{0, 8'd127, 28'h0400000, 3'd0, 32'h3D800000, 0, 0, 0, 6};
        vecs[3]  = '{0, 8'd127, 28'h4000004, 3'd0, 32'h3F800000, 0, 0, 1, 2};
        vecs[4]  = '{0, 8'd127, 28'h400000C, 3'd0, 32'h3F800002, 0, 0, 1, 2};
        vecs[5]  = '{0, 8'd254, 28'h8000000, 3'd0, 32'h7F800000, 1, 0, 1, 2};
        vecs[6]  = '{1, 8'd127, 28'h1234567, 3'd3, 32'h7FC00000, 0, 0, 0, 2};
        vecs[7]  = '{1, 8'd127, 28'h0000000, 3'd0, 32'h00000000, 0, 0, 0, 2};
        vecs[8]  = '{0, 8'd1,   28'h0000010, 3'd0, 32'h00000002, 0, 0, 0, 2};
        vecs[9]  = '{0, 8'd1,   28'h0000014, 3'd0, 32'h00000002, 0, 1, 1, 2};
        vecs[10] = '{0, 8'd0,   28'h0000010, 3'd0, 32'h00000002, 0, 0, 0, 2};
        vecs[11] = '{0, 8'd3,   28'h0400000, 3'd0, 32'h00200000, 0, 0, 0, 4};
        vecs[12] = '{1, 8'd100, 28'h0000000, 3'd1, 32'h80000000, 0, 0, 0, 2};
        vecs[13] = '{0, 8'd50,  28'h0000000, 3'd2, 32'h7F800000, 0, 0, 0, 2};
        vecs[14] = '{1, 8'd200, 28'h0ABCDEF, 3'd6, 32'h7FC00000, 0, 0, 0, 2};
        vecs[15] = '{1, 8'd127, 28'h7FFFFFC, 3'd0, 32'hC0000000, 0, 0, 1, 2};
        vecs[16] = '{0, 8'd127, 28'hC000003, 3'd0, 32'h40400000, 0, 0, 1, 2};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sign = 1'b0; exp = 8'd0; mantis_sum = '0; type_res = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.state", {28'd0, in_ready, out_valid, 2'b00}, 32'b1000);
        check("reset.result", result, 32'h0);
        check("reset.flags", {29'd0, flag_ovf, flag_unf, flag_inexact}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++)
            run_op(vecs[i], $sformatf("vec%0d", i), 0);

        // Stall the consumer for 5 cycles on a denormal result
        run_op(vecs[8], "backpressure", 5);

        // Reset in the middle of a multi-cycle NORM; result from the previous op is nonzero
        @(negedge clk);
        sign = 1'b0; exp = 8'd127; mantis_sum = 28'h0400000; type_res = 3'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset.valid_ready", {30'd0, out_valid, in_ready}, 32'b01);
        check("midreset.result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(vecs[1], "after_reset", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
